// File: rtl/sample_packer.sv
// sample_packer: packs a serial sample stream into 8-lane frames for the
// lane-mask filter. Short frames end on in_last and are zero-padded.
// One pending frame of buffering lets the input side overlap a stalled output.
module sample_packer #(
    parameter int DW    = 8,
    parameter int LANES = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [DW-1:0] o1,
    output logic [DW-1:0] o2,
    output logic [DW-1:0] o3,
    output logic [DW-1:0] o4,
    output logic [DW-1:0] o5,
    output logic [DW-1:0] o6,
    output logic [DW-1:0] o7,
    output logic [DW-1:0] o8,
    output logic [3:0]    ind,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int IW = $clog2(LANES);

    // FILL accepts samples; PEND holds a completed frame until the output slot frees.
    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   pack      [LANES];
    logic [DW-1:0]   frame     [LANES];
    logic [DW-1:0]   out_lane  [LANES];
    logic [IW:0]     cnt;
    logic            slot_free;
    logic            accept;
    logic            complete;
    logic            load_pend;
    logic            load_new;
    logic            load;

    assign slot_free = !out_valid || out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples its inputs from the same pre-edge values.
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    // Next-state and handshake decode; in_ready depends on state only.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        complete  = 1'b0;
        load_pend = 1'b0;
        load_new  = 1'b0;
        unique case (state)
            FILL: begin
                in_ready = 1'b1;
                accept   = in_valid;
                complete = in_valid && (in_last || cnt == (IW+1)'(LANES-1));
                load_new = complete && slot_free;
                if (complete && !slot_free) state_nxt = PEND;
            end
            PEND: begin
                load_pend = slot_free;
                if (slot_free) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    assign load = load_pend || load_new;

    // Frame as it would be loaded: pack buffer plus the sample arriving this cycle.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            frame[i] = (accept && cnt == (IW+1)'(i)) ? in_data : pack[i];
        end
    end

    // Pack buffer, lane counter and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the pack buffer is reset lane by lane because unfilled lanes
            // must read back as zero padding; it is a handful of flops, not a RAM.
            for (int i = 0; i < LANES; i++) begin
                pack[i]     <= '0;
                out_lane[i] <= '0;
            end
            cnt       <= '0;
            ind       <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < LANES; i++) begin
                out_lane[i] <= frame[i];
                pack[i]     <= '0;
            end
            ind       <= load_pend ? 4'(cnt) : 4'(cnt + 1'b1);
            out_valid <= 1'b1;
            cnt       <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                pack[cnt[IW-1:0]] <= in_data;
                cnt               <= cnt + 1'b1;
            end
        end
    end

    assign o1 = out_lane[0];
    assign o2 = out_lane[1];
    assign o3 = out_lane[2];
    assign o4 = out_lane[3];
    assign o5 = out_lane[4];
    assign o6 = out_lane[5];
    assign o7 = out_lane[6];
    assign o8 = out_lane[7];

endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: directed and randomized stimulus against a frame-queue
// reference model of sample_packer.
module tb_sample_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8;
    logic [3:0] ind;
    logic       out_valid;
    logic       out_ready;

    sample_packer #(.DW(8), .LANES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .o1        (o1),
        .o2        (o2),
        .o3        (o3),
        .o4        (o4),
        .o5        (o5),
        .o6        (o6),
        .o7        (o7),
        .o8        (o8),
        .ind       (ind),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: completed frames not yet consumed, oldest first, plus
    // the frame being gathered. Head of the queue is what the output shows;
    // a second entry means a frame is waiting and input is stalled.
    typedef struct packed {
        logic [3:0]  n;
        logic [63:0] lanes;
    } frame_t;

    frame_t      q[$];
    logic [63:0] cur;
    int          cur_n;

    task automatic model_reset();
        q.delete();
        cur   = '0;
        cur_n = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lanes_obs();
        return {o8, o7, o6, o5, o4, o3, o2, o1};
    endfunction

    // Compare DUT outputs against the model's view of the current cycle.
    task automatic compare_outputs(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        check({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
        if (q.size() > 0) begin
            check({tag, ".lanes"}, lanes_obs(), q[0].lanes);
            check({tag, ".ind"},   64'(ind),    64'(q[0].n));
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".in_ready"},  64'(in_ready),  64'd1);
        check({tag, ".lanes"},     lanes_obs(),    64'd0);
        check({tag, ".ind"},       64'(ind),       64'd0);
    endtask

    // One clock cycle: drive inputs, check outputs, advance model at the edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic r);
        logic acc, con;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        compare_outputs("cyc");
        acc = v && (q.size() < 2);
        con = r && (q.size() > 0);
        @(posedge clk);
        if (con) void'(q.pop_front());
        if (acc) begin
            cur[cur_n*8 +: 8] = d;
            cur_n++;
            if (l || cur_n == 8) begin
                q.push_back('{n: 4'(cur_n), lanes: cur});
                cur   = '0;
                cur_n = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        // Full frame 0x11..0x88, visible one cycle after the 8th accept.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b1);
        #1;
        check("full.o1",  64'(o1),  64'h11);
        check("full.o8",  64'(o8),  64'h88);
        check("full.ind", 64'(ind), 64'd8);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Partial frame ending on in_last, zero-padded.
        cycle(1'b1, 8'hA1, 1'b0, 1'b1);
        cycle(1'b1, 8'hA2, 1'b0, 1'b1);
        cycle(1'b1, 8'hA3, 1'b1, 1'b1);
        #1;
        check("part.lanes", lanes_obs(), 64'h0000_0000_00A3_A2A1);
        check("part.ind",   64'(ind),    64'd3);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure: two full frames with the output stalled.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        #1;
        check("bp.pend_ready", 64'(in_ready), 64'd0);
        check("bp.first_o1",   64'(o1),       64'h20);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        check("bp.swap_valid", 64'(out_valid), 64'd1);
        check("bp.swap_o1",    64'(o1),        64'h28);
        check("bp.swap_ready", 64'(in_ready),  64'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Sustained streaming: 32 samples, no input bubble.
        for (int i = 0; i < 32; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Single-sample frame, then in_last on the 8th sample.
        cycle(1'b1, 8'h5C, 1'b1, 1'b1);
        #1;
        check("single.lanes", lanes_obs(), 64'h0000_0000_0000_005C);
        check("single.ind",   64'(ind),    64'd1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h90 + i), 1'(i == 7), 1'b1);
        #1;
        check("last8.ind", 64'(ind), 64'd8);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-frame, asserted between edges.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_cleared("midrst");
        model_reset();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b1);
        #1;
        check("midrst.o1", 64'(o1), 64'hD0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 800; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 2) != 0));
        end

        // Reset while a frame is presented and another is pending.
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
        rst = 1'b1;
        #1;
        check_cleared("pendrst");
        model_reset();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sample_packer.md
Name: sample_packer

Overview:
- Upstream feeder for the 8-lane lane-mask filter in the radix-2 pipelined FFT datapath.
- Collects a serial byte stream into 8-lane frames and outputs them as o1..o8 together with a valid-lane count ind, which the filter uses to mask the lanes.
- Partial frames, terminated by in_last, are zero-padded.
- Valid/ready handshake on both sides, with one frame of buffering so input and output can overlap.

Parameters:
- DW, 8, sample width in bits. Lane ports o1..o8 are DW wide.
- LANES, 8, lanes per frame. Fixed at 8 to match the filter's 8 lanes.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  DW  sample
- in_valid  input  1  in_data is valid
- in_last  input  1  this sample ends the frame; qualified by in_valid
- in_ready  output  1  block accepts a sample this cycle
- o1..o8  output  DW each  frame lanes 0..7; o1 holds the first sample
- ind  output  4  number of valid lanes, 1..8
- out_valid  output  1  frame on o1..o8/ind is valid
- out_ready  input  1  downstream consumes the frame

Behaviour:
- Reset (async, active-high):
  - o1..o8=0, ind=0, out_valid=0.
  - Pack buffer cleared, cnt=0, pend=0, so in_ready=1.
- Accept: in_valid && in_ready at a rising edge.
  - in_data is written to pack lane cnt, then cnt increments.
- Frame completion: an accept where cnt==7 (8th sample) or in_last=1.
- Output slot free: !out_valid || out_ready.
- Completion with slot free:
  - At that same edge, the output registers load the pack contents including the incoming sample.
  - Unfilled lanes are loaded as 0; ind = cnt+1.
  - out_valid=1 from the next cycle.
  - Pack buffer clears to all lanes 0, cnt=0.
  - Latency: last sample accepted at edge N, frame visible after edge N.
- Completion with slot not free:
  - Sample is written, pend=1, cnt holds the frame size.
  - in_ready=0 while pend=1.
- pend=1 with slot free: transfer at that edge, pend=0, buffer cleared; in_ready=1 next cycle.
- Output handshake:
  - out_valid && out_ready consumes the frame.
  - out_valid drops at that edge unless a new frame loads at the same edge; in that case out_valid stays 1 with the new contents.
- Output stability: while out_valid=1 && out_ready=0, o1..o8 and ind hold stable.
- in_ready = !pend, combinational from state only. It never depends on out_ready, so there is no combinational in→out path.
- in_last when cnt==7 is equivalent to the 8th sample: ind=8.
- in_last/in_data are ignored when in_valid=0 or in_ready=0.
- Zero-length frames do not exist: ind is never 0 while out_valid=1.
- Throughput: one sample per cycle sustained when out_ready=1. Back-to-back full frames produce out_valid every 8 cycles with no bubble on input.
- Reset mid-frame: the partial pack buffer and any pending or presented frame are dropped. No output after reset until a new frame completes.
- States:
  - FILL (pend=0): accepting samples.
  - PEND (pend=1): frame complete, waiting for the output slot.
  - Transitions: FILL→PEND on completion with slot not free; PEND→FILL on transfer.
  - The output register's valid state (out_valid) is independent of FILL/PEND.

Test Plan:
- Full frame: 0x11..0x88 on consecutive cycles, out_ready=1, in_last=0 → one cycle after the 8th accept, out_valid=1, o1=0x11..o8=0x88, ind=8.
- Partial frame: 0xA1,0xA2,0xA3 with in_last on 0xA3 → o1..o3=A1,A2,A3, o4..o8=0, ind=3. The next frame starts cleanly at lane 0.
- Backpressure:
  - Setup: out_ready=0, two full frames streamed.
  - First frame presented and held stable.
  - Second frame completes, then in_ready=0 (PEND).
  - Raise out_ready for one cycle: the second frame replaces the first with out_valid continuous, and in_ready=1 the next cycle.
- Sustained streaming: 32 samples with in_valid and out_ready tied high → in_ready stays 1, four frames with ind=8 every 8 cycles, data in order.
- Single-sample frame: 0x5C with in_last at cnt=0 → o1=0x5C, ind=1, others 0. Also in_last on the 8th sample gives ind=8.
- Reset mid-frame: assert rst after 5 samples, asynchronously between edges → outputs immediately 0 and in_ready=1. Then 8 new samples produce a frame containing only the new data.
